param_fifo: RTL and testbench

Synchronous valid/ready FIFO with a type parameter for the element type and a value parameter for the depth. It is the buffering stage placed directly upstream of a type-parameterised consumer instance. Its `out_data` port uses the same `T` as the consumer's input port. Elaboration checks that a type parameter propagates through a sequential block and its port assignments.

---
 rtl/param_fifo.sv | 109 ++++++++++
 tb/tb_param_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo
//
// Synchronous valid/ready FIFO. The element type is a type parameter so the
// FIFO can sit directly in front of a consumer that uses the same type, and the
// depth is any integer >= 1 (not restricted to powers of two).
//
// Parameters:
//   T      element type (any packed type), default bit
//   DEPTH  number of entries, default 4
//   CW     width of count, derived from DEPTH; never overridden
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset (clears pointers and occupancy)
//   in_valid   producer offers in_data
//   in_ready   FIFO can accept an element this cycle (not full)
//   in_data    element to push
//   out_valid  FIFO holds at least one element
//   out_ready  consumer takes out_data this cycle
//   out_data   head element, all-zero while empty
//   count      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module param_fifo #(
    parameter type T     = bit,
    parameter int  DEPTH = 4,
    parameter int  CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  T              in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output T              out_data,
    output logic [CW-1:0] count
);

    // A one-entry FIFO still needs a 1-bit pointer; it simply never leaves 0.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    // Storage is deliberately not reset: out_valid masks stale entries.
    T mem_q [DEPTH];

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic push;
    logic pop;

    // Handshake outputs depend only on registered occupancy, so there is no
    // combinational path from in_valid/out_ready to in_ready/out_valid.
    assign in_ready  = (cnt_q != CNT_FULL);
    assign out_valid = (cnt_q != '0);
    assign count     = cnt_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Head is presented only while valid; no bypass of an incoming push.
    assign out_data = out_valid ? mem_q[rp_q] : T'('0);

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;

        // Explicit wrap so non-power-of-two depths work.
        if (push) begin
            wp_d = (wp_q == PTR_LAST) ? '0 : wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = (rp_q == PTR_LAST) ? '0 : rp_q + PW'(1);
        end

        // Simultaneous push and pop leaves occupancy unchanged.
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Array write kept in its own reset-free block so it maps onto RAM.
    // A push is blocked while rst is high.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wp_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
module tb_param_fifo;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: int, DEPTH=4
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    int         a_in_data, a_out_data;
    logic [2:0] a_count;

    // Instance B: int, DEPTH=3
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    int         b_in_data, b_out_data;
    logic [1:0] b_count;

    // Instance C: int, DEPTH=2
    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    int         c_in_data, c_out_data;
    logic [1:0] c_count;

    // Instance D: default parameters (bit, DEPTH=4)
    logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    bit         d_in_data, d_out_data;
    logic [2:0] d_count;

    param_fifo #(.T(int), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count)
    );

    param_fifo #(.T(int), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count)
    );

    param_fifo #(.T(int), .DEPTH(2)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .count(c_count)
    );

    param_fifo u_d (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .count(d_count)
    );

    // Advance one edge, then settle away from it before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b1; a_in_data = 77;
        b_in_valid = 1'b1; b_in_data = 77;
        c_in_valid = 1'b1; c_in_data = 77;
        d_in_valid = 1'b1; d_in_data = 1'b1;
        a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0; d_out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0; d_in_valid = 1'b0;
        checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL reset_a_count got %0d exp 0", a_count); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready got %b exp 1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got %b exp 0", a_out_valid); end
        checks++; if (a_out_data !== 0) begin errors++; $display("FAIL reset_a_out_data got %0d exp 0", a_out_data); end
        checks++; if (b_count !== 2'd0) begin errors++; $display("FAIL reset_b_count got %0d exp 0", b_count); end
        checks++; if (c_count !== 2'd0) begin errors++; $display("FAIL reset_c_count got %0d exp 0", c_count); end
        checks++; if (d_count !== 3'd0 || d_out_valid !== 1'b0) begin errors++; $display("FAIL reset_d got count=%0d ov=%b exp count=0 ov=0", d_count, d_out_valid); end
        $display("reset done");
    endtask

    task automatic test_fill_drain();
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 10 + i;
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready%0d got %b exp 1", i, a_in_ready); end
            if (i == 0) begin
                // No empty bypass: nothing visible before the edge
                checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fill_no_bypass got %b exp 0", a_out_valid); end
            end
            step();
            $display("push a data=%0d", 10 + i);
            checks++; if (a_count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count%0d got %0d exp %0d", i, a_count, i + 1); end
            if (i == 0) begin
                checks++; if (a_out_valid !== 1'b1 || a_out_data !== 10) begin errors++; $display("FAIL fill_latency got ov=%b data=%0d exp ov=1 data=10", a_out_valid, a_out_data); end
            end
        end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", a_in_ready); end
        a_in_data = 14;
        step();
        checks++; if (a_count !== 3'd4) begin errors++; $display("FAIL full_reject_count got %0d exp 4", a_count); end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== 10 + i) begin errors++; $display("FAIL drain%0d got ov=%b data=%0d exp ov=1 data=%0d", i, a_out_valid, a_out_data, 10 + i); end
            step();
            $display("pop a data=%0d", 10 + i);
        end
        a_out_ready = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_count !== 3'd0 || a_out_data !== 0) begin errors++; $display("FAIL drain_empty got ov=%b count=%0d data=%0d exp 0 0 0", a_out_valid, a_count, a_out_data); end
    endtask

    task automatic test_back_to_back();
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 1;
        step();
        b_in_data   = 2;
        step();
        checks++; if (b_count !== 2'd2) begin errors++; $display("FAIL b2b_preload got %0d exp 2", b_count); end
        b_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b_in_data = 3 + i;
            checks++; if (b_count !== 2'd2 || b_out_data !== 1 + i) begin errors++; $display("FAIL b2b%0d got count=%0d data=%0d exp count=2 data=%0d", i, b_count, b_out_data, 1 + i); end
            step();
            $display("push b data=%0d pop b data=%0d", 3 + i, 1 + i);
        end
        b_in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (b_out_valid !== 1'b1 || b_out_data !== 7 + i) begin errors++; $display("FAIL b2b_tail%0d got ov=%b data=%0d exp ov=1 data=%0d", i, b_out_valid, b_out_data, 7 + i); end
            step();
        end
        b_out_ready = 1'b0;
        checks++; if (b_out_valid !== 1'b0 || b_count !== 2'd0) begin errors++; $display("FAIL b2b_empty got ov=%b count=%0d exp 0 0", b_out_valid, b_count); end
    endtask

    task automatic test_full_pop();
        c_out_ready = 1'b0;
        c_in_valid  = 1'b1;
        c_in_data   = 21;
        step();
        c_in_data   = 22;
        step();
        checks++; if (c_count !== 2'd2 || c_in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_full got count=%0d ir=%b exp 2 0", c_count, c_in_ready); end
        c_in_data   = 23;
        c_out_ready = 1'b1;
        step();
        $display("pop c data=21");
        c_in_valid = 1'b0;
        checks++; if (c_count !== 2'd1 || c_out_data !== 22) begin errors++; $display("FAIL fullpop_one got count=%0d data=%0d exp 1 22", c_count, c_out_data); end
        step();
        c_out_ready = 1'b0;
        checks++; if (c_count !== 2'd0 || c_out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_nobypass got count=%0d ov=%b exp 0 0", c_count, c_out_valid); end
    endtask

    task automatic test_default();
        bit pattern [4];
        pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b1; pattern[3] = 1'b0;
        d_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d_in_valid = 1'b1;
            d_in_data  = pattern[i];
            step();
        end
        d_in_valid = 1'b0;
        checks++; if (d_count !== 3'd4 || d_in_ready !== 1'b0) begin errors++; $display("FAIL default_full got count=%0d ir=%b exp 4 0", d_count, d_in_ready); end
        d_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (d_out_valid !== 1'b1 || d_out_data !== pattern[i]) begin errors++; $display("FAIL default_out%0d got ov=%b data=%b exp ov=1 data=%b", i, d_out_valid, d_out_data, pattern[i]); end
            step();
            $display("pop d data=%b", pattern[i]);
        end
        d_out_ready = 1'b0;
        checks++; if (d_out_valid !== 1'b0 || d_count !== 3'd0) begin errors++; $display("FAIL default_empty got ov=%b count=%0d exp 0 0", d_out_valid, d_count); end
    endtask

    task automatic test_mid_reset();
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 1 + i;
            step();
        end
        checks++; if (a_count !== 3'd3) begin errors++; $display("FAIL midrst_pre got %0d exp 3", a_count); end
        rst       = 1'b1;
        a_in_data = 99;
        step();
        rst        = 1'b0;
        a_in_valid = 1'b0;
        checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 0) begin errors++; $display("FAIL midrst_clear got count=%0d ov=%b ir=%b data=%0d exp 0 0 1 0", a_count, a_out_valid, a_in_ready, a_out_data); end
        a_in_valid = 1'b1;
        a_in_data  = 5;
        step();
        a_in_valid = 1'b0;
        checks++; if (a_count !== 3'd1 || a_out_valid !== 1'b1 || a_out_data !== 5) begin errors++; $display("FAIL midrst_push got count=%0d ov=%b data=%0d exp 1 1 5", a_count, a_out_valid, a_out_data); end
        a_out_ready = 1'b1;
        step();
        $display("pop a data=5");
        a_out_ready = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_count !== 3'd0) begin errors++; $display("FAIL midrst_empty got ov=%b count=%0d exp 0 0", a_out_valid, a_count); end
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_data = 0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 0; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = 0; c_out_ready = 1'b0;
        d_in_valid = 1'b0; d_in_data = 1'b0; d_out_ready = 1'b0;
        #1;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_pop();
        test_default();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
